// File: rtl/dmem_bus_bridge_pkg.sv
// Shared types for the data-memory bus bridge.
// Holds the FSM state encoding and the word-alignment mask.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_bus_bridge_if.sv
// Word-addressed memory bus with req/ack handshake.
// master: bridge drives req/we/addr/wdata; slave: memory drives rdata/ack/err.
interface dmem_bus_bridge_if #(
  parameter int ADDR_W = 32
);

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ack;
  logic              bus_err;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack,
    input  bus_err
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack,
    output bus_err
  );

endinterface

// File: rtl/dmem_bus_bridge_timeout_ctr.sv
// Bus-cycle counter for the bridge; expired is high in the last allowed cycle.
// Ports: clk, Reset (sync, active-high), clr, en, expired.
module dmem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = (cnt_q == LIMIT);

  // Holding at the limit keeps the count from wrapping even if en lingers.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// Multi-cycle bridge from the CPU data port to a req/ack memory bus.
// Ports: clk, Reset, cpu_* request/response, bus (master modport).
module dmem_bus_bridge
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic               cpu_ready,
  output logic               cpu_err,
  dmem_bus_bridge_if.master  bus
);

  state_e state_q, state_d;

  logic              we_q, we_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              expired;

  dmem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .Reset  (Reset),
    .clr    (state_q != BUS),
    .en     (state_q == BUS),
    .expired(expired)
  );

  assign bus.bus_req   = (state_q == BUS);
  assign bus.bus_we    = (state_q == BUS) && we_q;
  assign bus.bus_addr  = {addr_q, 2'b00};
  assign bus.bus_wdata = wdata_q;

  assign cpu_ready = (state_q == DONE);
  assign cpu_err   = (state_q == DONE) && err_q;
  assign cpu_rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr[ADDR_W-1:2];
          wdata_d = cpu_wdata;
          err_d   = 1'b0;
          if ((cpu_addr[1:0] & WORD_ALIGN_MASK) != 2'b00) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = BUS;
          end
        end
      end
      BUS: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (bus.bus_ack) begin
          err_d = bus.bus_err;
          if (!we_q) begin
            rdata_d = bus.bus_rdata;
          end
          state_d = DONE;
        end else if (expired) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge with a short timeout.
// Stimulus pushes expected completions; a negedge monitor pops and compares.
module tb_dmem_bus_bridge;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        Reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;

  dmem_bus_bridge_if #(.ADDR_W(32)) bus ();

  dmem_bus_bridge #(
    .TIMEOUT_CYCLES(T),
    .ADDR_W        (32)
  ) dut (
    .clk      (clk),
    .Reset    (Reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .cpu_err  (cpu_err),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sbq[$];

  // Bus responder state, set up by the stimulus before each request.
  int          ack_wait = -1;
  logic [31:0] resp_rdata = '0;
  logic        resp_err = 1'b0;
  logic        noise_err = 1'b0;
  int          req_cycles = 0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_baddr = '0;
  logic [31:0] exp_bwdata = '0;

  initial begin
    bus.bus_ack   = 1'b0;
    bus.bus_err   = 1'b0;
    bus.bus_rdata = '0;
  end

  always @(negedge clk) begin
    if (bus.bus_req) begin
      check("bus_addr", bus.bus_addr, exp_baddr);
      check("bus_we", {31'd0, bus.bus_we}, {31'd0, exp_we});
      if (exp_we) check("bus_wdata", bus.bus_wdata, exp_bwdata);
      bus.bus_ack   = (req_cycles == ack_wait);
      bus.bus_rdata = bus.bus_ack ? resp_rdata : 32'h0BAD_0BAD;
      bus.bus_err   = bus.bus_ack ? resp_err : noise_err;
      req_cycles++;
    end else begin
      bus.bus_ack = 1'b0;
      bus.bus_err = noise_err;
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (cpu_ready) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ready: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.name, "_err"}, {31'd0, cpu_err}, {31'd0, e.err});
        if (e.chk_rd) check({e.name, "_rdata"}, cpu_rdata, e.rd);
        check({e.name, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  task automatic run(string name, logic we, logic [31:0] addr,
                     logic [31:0] wdata, int wait_n, logic [31:0] rdata,
                     logic rerr, logic noise, logic [31:0] exp_rd,
                     logic exp_err, logic chk_rd, int lat, int exp_cyc);
    int n;
    @(negedge clk);
    cpu_req    = 1'b1;
    cpu_we     = we;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
    ack_wait   = wait_n;
    resp_rdata = rdata;
    resp_err   = rerr;
    noise_err  = noise;
    exp_we     = we;
    exp_baddr  = {addr[31:2], 2'b00};
    exp_bwdata = wdata;
    req_cycles = 0;
    sbq.push_back('{exp_rd, exp_err, chk_rd, cyc + lat, name});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ready && n < 40);
    if (!cpu_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no ready expected ready", name);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end
    cpu_req   = 1'b0;
    noise_err = 1'b0;
    check({name, "_buscycles"}, req_cycles, exp_cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1);
  end

  initial begin
    Reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, cpu_ready}, 32'd0);
    check("rst_err", {31'd0, cpu_err}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_busreq", {31'd0, bus.bus_req}, 32'd0);
    check("rst_busaddr", bus.bus_addr, 32'd0);
    check("rst_buswdata", bus.bus_wdata, 32'd0);
    Reset = 1'b0;

    run("ld0w", 1'b0, 32'h0000_0104, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0,
        32'hDEAD_BEEF, 1'b0, 1'b1, 2, 1);
    run("st3w", 1'b1, 32'h0000_0200, 32'h1234_5678, 3, 32'h0, 1'b0, 1'b1,
        32'hDEAD_BEEF, 1'b0, 1'b1, 5, 4);
    run("misal", 1'b0, 32'h0000_0102, 32'h0, 0, 32'h0, 1'b0, 1'b0,
        32'h0, 1'b1, 1'b0, 1, 0);
    run("ldberr", 1'b0, 32'h0000_0010, 32'h0, 1, 32'h55AA_55AA, 1'b1, 1'b0,
        32'h55AA_55AA, 1'b1, 1'b1, 3, 2);
    run("tmo", 1'b0, 32'h0000_0300, 32'h0, -1, 32'h0, 1'b0, 1'b0,
        32'h0, 1'b1, 1'b1, 1 + T, T);
    run("acklim", 1'b0, 32'h0000_0400, 32'h0, T - 1, 32'hCAFE_F00D, 1'b0,
        1'b0, 32'hCAFE_F00D, 1'b0, 1'b1, 1 + T, T);
    run("misst", 1'b1, 32'h0000_0203, 32'hFFFF_0000, 0, 32'h0, 1'b0, 1'b0,
        32'h0, 1'b1, 1'b0, 1, 0);

    // Reset in the second BUS cycle.
    @(negedge clk);
    cpu_req    = 1'b1;
    cpu_we     = 1'b0;
    cpu_addr   = 32'h0000_0020;
    ack_wait   = -1;
    exp_we     = 1'b0;
    exp_baddr  = 32'h0000_0020;
    req_cycles = 0;
    @(negedge clk);
    @(negedge clk);
    Reset   = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    check("rstbus_req", {31'd0, bus.bus_req}, 32'd0);
    check("rstbus_ready", {31'd0, cpu_ready}, 32'd0);
    check("rstbus_rdata", cpu_rdata, 32'd0);
    check("rstbus_cycles", req_cycles, 32'd2);
    @(negedge clk);
    Reset = 1'b0;
    repeat (4) @(negedge clk);

    run("ldpost", 1'b0, 32'h0000_0008, 32'h0, 0, 32'hA5A5_0008, 1'b0, 1'b0,
        32'hA5A5_0008, 1'b0, 1'b1, 2, 1);

    repeat (3) @(negedge clk);
    check("sb_empty", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
